// File: rtl/demorgan_sweep_ctrl.sv
// demorgan_sweep_ctrl: steps a 2-bit De Morgan gate unit through all 16 A/B vectors,
// waits SETTLE cycles per vector, then checks o1/o2 (NOR) and p1/p2 (NAND) and tallies failures.
module demorgan_sweep_ctrl #(
   parameter int SETTLE = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic [1:0] o1,
   input  logic [1:0] o2,
   input  logic [1:0] p1,
   input  logic [1:0] p2,
   output logic [1:0] a_out,
   output logic [1:0] b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [4:0] err_count,
   output logic       fail_valid,
   output logic [3:0] first_fail
);
   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;
   state_t     state_q, state_d;
   logic [3:0] idx_q, idx_d, cnt_q, cnt_d, ff_q, ff_d;
   logic [4:0] err_q, err_d;
   logic       fv_q, fv_d, pass_q, pass_d, done_q, done_d, busy_q, busy_d;
   logic [1:0] nor_g, nand_g;
   logic       bad;

   always_comb begin
      nor_g  = ~(idx_q[3:2] | idx_q[1:0]);
      nand_g = ~(idx_q[3:2] & idx_q[1:0]);
      bad    = (o1 != nor_g) || (o2 != nor_g) || (p1 != nand_g) || (p2 != nand_g);
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fv_d    = fv_q;
      ff_d    = ff_q;
      pass_d  = pass_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = DRIVE;
               idx_d   = 4'd0;
               cnt_d   = 4'd0;
               err_d   = 5'd0;
               fv_d    = 1'b0;
               ff_d    = 4'd0;
               pass_d  = 1'b0;
            end
         end
         DRIVE: begin
            if (abort) state_d = IDLE;
            else if (cnt_q == 4'(SETTLE - 1)) state_d = CHECK;
            else cnt_d = cnt_q + 4'd1;
         end
         CHECK: begin
            // an aborted CHECK leaves the tally untouched, so its vector is not counted
            if (abort) state_d = IDLE;
            else begin
               if (bad) begin
                  err_d = err_q + 5'd1;
                  if (!fv_q) begin
                     fv_d = 1'b1;
                     ff_d = idx_q;
                  end
               end
               if (idx_q == 4'd15) begin
                  state_d = DONE;
                  pass_d  = (err_d == 5'd0);
               end else begin
                  state_d = DRIVE;
                  idx_d   = idx_q + 4'd1;
                  cnt_d   = 4'd0;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == DRIVE) || (state_d == CHECK);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         cnt_q   <= 4'd0;
         err_q   <= 5'd0;
         fv_q    <= 1'b0;
         ff_q    <= 4'd0;
         pass_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         ff_q    <= ff_d;
         pass_q  <= pass_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign a_out      = idx_q[3:2];
   assign b_out      = idx_q[1:0];
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_q;
   assign fail_valid = fv_q;
   assign first_fail = ff_q;
endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// tb_demorgan_sweep_ctrl: three sequencers (SETTLE 2, 1, 3) each beside a behavioural gate unit
// with selectable faults; sweep results are queued at start and checked when done pulses.
module tb_demorgan_sweep_ctrl;
   typedef struct {
      int         g;
      logic [4:0] ec;
      logic       fv;
      logic [3:0] ff;
      logic       ps;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] start, abort, busy, done, pass, fail_valid;
   logic [1:0] o1 [3], o2 [3], p1 [3], p2 [3], a_out [3], b_out [3];
   logic [4:0] err_count [3];
   logic [3:0] first_fail [3];
   int         mode [3];
   int         cyc = 0;
   int         passed = 0, total = 0;
   int         k;
   logic [4:0] ec;
   logic [3:0] ff;
   logic       fv;
   exp_t       sb [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // mode 0 good, 1 p2 stuck 11, 2 o1 inverted, 3 o1 inverted at vectors 3 and 6, 4 two-cycle delay
   function automatic logic [7:0] gate_out(input int md, input logic [3:0] v);
      logic [1:0] a, b, nr, nd, x;
      a  = v[3:2];
      b  = v[1:0];
      nr = ~(a | b);
      nd = ~(a & b);
      x  = (md == 2 || (md == 3 && (v == 4'd3 || v == 4'd6))) ? ~nr : nr;
      return {x, nr, nd, (md == 1) ? 2'b11 : nd};
   endfunction

   // with SETTLE=1 the delayed unit still shows the previous vector when sampled
   function automatic void delay_exp(output logic [4:0] e, output logic [3:0] f, output logic v);
      logic [3:0] seen;
      e = 0;
      f = 0;
      v = 0;
      for (int n = 0; n < 16; n++) begin
         seen = (n == 0) ? 4'd0 : 4'(n - 1);
         if (gate_out(0, seen) != gate_out(0, 4'(n))) begin
            if (!v) f = 4'(n);
            v = 1'b1;
            e = e + 5'd1;
         end
      end
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gd
      logic [1:0] ad1 = 2'd0, ad2 = 2'd0, bd1 = 2'd0, bd2 = 2'd0;
      logic [7:0] go;
      always @(posedge clk) begin
         ad1 <= a_out[g];
         ad2 <= ad1;
         bd1 <= b_out[g];
         bd2 <= bd1;
      end
      assign go = (mode[g] == 4) ? gate_out(0, {ad2, bd2}) : gate_out(mode[g], {a_out[g], b_out[g]});
      assign {o1[g], o2[g], p1[g], p2[g]} = go;
      demorgan_sweep_ctrl #(.SETTLE(g == 0 ? 2 : (g == 1 ? 1 : 3))) dut (
         .clk(clk), .rst_n(rst_n), .start(start[g]), .abort(abort[g]),
         .o1(o1[g]), .o2(o2[g]), .p1(p1[g]), .p2(p2[g]),
         .a_out(a_out[g]), .b_out(b_out[g]), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
         .err_count(err_count[g]), .fail_valid(fail_valid[g]), .first_fail(first_fail[g])
      );
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act === expv) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
   endtask

   function automatic int settle(input int g);
      return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
   endfunction

   task automatic push(input int g, input logic [4:0] e, input logic v, input logic [3:0] f,
                       input logic ps, input int dc);
      exp_t x;
      x.g   = g;
      x.ec  = e;
      x.fv  = v;
      x.ff  = f;
      x.ps  = ps;
      x.cyc = dc;
      sb.push_back(x);
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         total++;
         $display("FAIL timeout: %0d sweep results outstanding at cycle %0d", sb.size(), cyc);
         sb.delete();
      end
   endtask

   task automatic sweep(input int g, input int md, input logic [4:0] e, input logic v,
                        input logic [3:0] f, input logic ps);
      @(negedge clk);
      mode[g]  = md;
      start[g] = 1'b1;
      push(g, e, v, f, ps, cyc + 16 * (settle(g) + 1) + 1);
      @(negedge clk);
      start[g] = 1'b0;
      wait_empty();
   endtask

   task automatic check_rst(input int g);
      chk("rst_a_out", a_out[g], 0);
      chk("rst_b_out", b_out[g], 0);
      chk("rst_busy", busy[g], 0);
      chk("rst_done", done[g], 0);
      chk("rst_pass", pass[g], 0);
      chk("rst_err_count", err_count[g], 0);
      chk("rst_fail_valid", fail_valid[g], 0);
      chk("rst_first_fail", first_fail[g], 0);
   endtask

   always @(negedge clk) begin
      for (int g = 0; g < 3; g++) begin
         if (done[g]) begin
            if (sb.size() == 0 || sb[0].g != g) begin
               total++;
               $display("FAIL done_unexpected: inst %0d pulsed done at cycle %0d", g, cyc);
            end else begin
               chk("done_cycle", cyc, sb[0].cyc);
               chk("err_count", err_count[g], sb[0].ec);
               chk("fail_valid", fail_valid[g], sb[0].fv);
               chk("first_fail", first_fail[g], sb[0].ff);
               chk("pass", pass[g], sb[0].ps);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      start = 3'b000;
      abort = 3'b000;
      for (int g = 0; g < 3; g++) mode[g] = 0;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 3; g++) check_rst(g);
      rst_n = 1'b1;
      @(negedge clk);
      start[0] = 1'b1;
      push(0, 5'd0, 1'b0, 4'd0, 1'b1, cyc + 49);
      for (int m = 1; m <= 49; m++) begin
         @(negedge clk);
         start[0] = 1'b0;
         if (m == 1 || m == 48) chk("busy_on", busy[0], 1);
         if (m == 49) chk("busy_off", busy[0], 0);
         if (m % 3 == 0 && m <= 48) chk("vector", {a_out[0], b_out[0]}, m / 3 - 1);
      end
      wait_empty();
      sweep(0, 1, 5'd7, 1'b1, 4'd5, 1'b0);
      sweep(0, 2, 5'd16, 1'b1, 4'd0, 1'b0);
      @(negedge clk);
      mode[0]  = 3;
      start[0] = 1'b1;
      for (int m = 1; m <= 26; m++) begin
         @(negedge clk);
         start[0] = 1'b0;
         if (m == 21) abort[0] = 1'b1;
         if (m == 22) begin
            abort[0] = 1'b0;
            chk("abort_busy", busy[0], 0);
            chk("abort_done", done[0], 0);
            chk("abort_err_count", err_count[0], 1);
            chk("abort_first_fail", first_fail[0], 3);
            chk("abort_fail_valid", fail_valid[0], 1);
            chk("abort_pass", pass[0], 0);
         end
      end
      @(negedge clk);
      mode[0]  = 0;
      start[0] = 1'b1;
      push(0, 5'd0, 1'b0, 4'd0, 1'b1, cyc + 49);
      @(negedge clk);
      start[0] = 1'b0;
      chk("restart_err_count", err_count[0], 0);
      chk("restart_fail_valid", fail_valid[0], 0);
      chk("restart_first_fail", first_fail[0], 0);
      wait_empty();
      @(negedge clk);
      start[0] = 1'b1;
      for (int m = 1; m <= 28; m++) begin
         @(negedge clk);
         start[0] = 1'b0;
      end
      chk("pre_reset_vector", {a_out[0], b_out[0]}, 9);
      rst_n = 1'b0;
      #1;
      check_rst(0);
      @(negedge clk);
      rst_n = 1'b1;
      sweep(0, 0, 5'd0, 1'b0, 4'd0, 1'b1);
      @(negedge clk);
      for (int g = 0; g < 3; g++) mode[g] = 4;
      start = 3'b111;
      delay_exp(ec, ff, fv);
      push(1, ec, fv, ff, ec == 5'd0, cyc + 33);
      push(0, 5'd0, 1'b0, 4'd0, 1'b1, cyc + 49);
      push(2, 5'd0, 1'b0, 4'd0, 1'b1, cyc + 65);
      @(negedge clk);
      start = 3'b000;
      wait_empty();
      @(negedge clk);
      mode[2]  = 0;
      start[2] = 1'b1;
      k = cyc;
      push(2, 5'd0, 1'b0, 4'd0, 1'b1, k + 65);
      push(2, 5'd0, 1'b0, 4'd0, 1'b1, k + 131);
      repeat (70) @(negedge clk);
      start[2] = 1'b0;
      wait_empty();
      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
